// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing one-hot-or-zero drive enables for a shared
// tristate bus, with a per-grant hold limit and a fixed idle turnaround gap.
module bus_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MAX_HOLD = 4,
  parameter int TURN     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         en,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     preempt
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

  state_t          state, nextState;
  logic [OW-1:0]   last, nextLast, nextOwner, win;
  logic [N_REQ-1:0] nextEn;
  logic [HW-1:0]   holdCnt, nextHold;
  logic [TW-1:0]   turnCnt, nextTurn;
  logic            nextPreempt;

  // Scan downward so the lowest offset from last+1 is the final assignment.
  always_comb begin
    int idx;
    win = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (req[idx]) win = OW'(idx);
    end
  end

  always_comb begin
    nextState   = state;
    nextEn      = en;
    nextOwner   = owner;
    nextLast    = last;
    nextHold    = holdCnt;
    nextTurn    = turnCnt;
    nextPreempt = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          nextState       = GRANT;
          nextEn          = '0;
          nextEn[win]     = 1'b1;
          nextOwner       = win;
          nextLast        = win;
          nextHold        = HW'(1);
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          nextState = TURNAROUND;
          nextEn    = '0;
          nextTurn  = TW'(1);
        end else if (holdCnt == HW'(MAX_HOLD)) begin
          nextState   = TURNAROUND;
          nextEn      = '0;
          nextTurn    = TW'(1);
          nextPreempt = 1'b1;
        end else begin
          nextHold = holdCnt + HW'(1);
        end
      end
      TURNAROUND: begin
        nextEn = '0;
        if (turnCnt == TW'(TURN)) begin
          if (req != '0) begin
            nextState   = GRANT;
            nextEn[win] = 1'b1;
            nextOwner   = win;
            nextLast    = win;
            nextHold    = HW'(1);
          end else begin
            nextState = IDLE;
          end
        end else begin
          nextTurn = turnCnt + TW'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextEn    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      en      <= '0;
      owner   <= '0;
      last    <= OW'(N_REQ - 1);
      holdCnt <= '0;
      turnCnt <= '0;
      preempt <= 1'b0;
    end else begin
      state   <= nextState;
      en      <= nextEn;
      owner   <= nextOwner;
      last    <= nextLast;
      holdCnt <= nextHold;
      turnCnt <= nextTurn;
      preempt <= nextPreempt;
    end
  end

  assign busy = |en;

endmodule
